// File: rtl/majority_pkg.sv
// Shared definitions for the sequential majority voter.
// Holds the FSM state encoding and the helpers that derive the count-field
// width (CW) and the number of count beats (NB) from WIDTH/CHUNK.
package majority_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bits needed to hold a count in the range 0..width.
   function automatic int calc_cw(input int width);
      return $clog2(width + 1);
   endfunction

   // Number of CHUNK-sized beats needed to cover a word.
   function automatic int calc_nb(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
// Ports:
//   bits  - CHUNK-bit slice to count
//   count - number of 1 bits in the slice, $clog2(CHUNK+1) bits wide
module popcount_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0]           bits,
   output logic [$clog2(CHUNK+1)-1:0] count
);

   localparam int PCW = $clog2(CHUNK + 1);

   always_comb begin
      count = '0;
      for (int i = 0; i < CHUNK; i++) begin
         count = count + PCW'(bits[i]);
      end
   end

endmodule

// File: rtl/majority_voter_seq.sv
// Sequential majority voter: accepts a WIDTH-bit word, counts its 1 bits
// CHUNK bits per clock, then reports the count, a majority/threshold decision
// and an exact-half tie flag until the consumer takes the result.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid/ready   - input handshake (ready only while idle)
//   in_data          - word to vote on
//   in_mode          - 0: strict majority, 1: count >= in_thresh
//   in_thresh        - threshold for mode 1
//   out_valid/ready  - result handshake
//   out_maj, out_count, out_tie - vote result, popcount, exact-half flag
module majority_voter_seq
   import majority_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int CHUNK = 4,
   localparam int CW    = calc_cw(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic          in_mode,
   input  logic [CW-1:0] in_thresh,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_maj,
   output logic [CW-1:0] out_count,
   output logic          out_tie
);

   localparam int NB   = calc_nb(WIDTH, CHUNK);
   localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
   localparam int PCW  = $clog2(CHUNK + 1);
   localparam bit EVEN = (WIDTH % 2) == 0;
   localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

   if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("majority_voter_seq: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state, nxt;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    acc;
   logic [BW-1:0]    beat;
   logic             mode_q;
   logic [CW-1:0]    thresh_q;
   logic [PCW-1:0]   pc;
   logic [CW-1:0]    sum;
   logic             last_beat;
   logic             maj_next;
   logic             tie_next;

   popcount_chunk #(.CHUNK(CHUNK)) u_pc (
      .bits  (shreg[CHUNK-1:0]),
      .count (pc)
   );

   // Max sum is WIDTH, which fits CW bits by construction.
   assign sum       = acc + CW'(pc);
   assign last_beat = (beat == BW'(NB - 1));
   // Thresholds above WIDTH can never be met; threshold 0 is always met.
   assign maj_next  = mode_q ? (sum >= thresh_q) : (sum > HALF);
   assign tie_next  = EVEN && (sum == HALF);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (in_valid)  nxt = COUNT;
         COUNT:   if (last_beat) nxt = DONE;
         DONE:    if (out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg     <= '0;
         acc       <= '0;
         beat      <= '0;
         mode_q    <= 1'b0;
         thresh_q  <= '0;
         out_count <= '0;
         out_maj   <= 1'b0;
         out_tie   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= in_data;
                  mode_q   <= in_mode;
                  thresh_q <= in_thresh;
                  acc      <= '0;
                  beat     <= '0;
               end
            end
            COUNT: begin
               acc   <= sum;
               shreg <= shreg >> CHUNK;
               beat  <= beat + BW'(1);
               if (last_beat) begin
                  out_count <= sum;
                  out_maj   <= maj_next;
                  out_tie   <= tie_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_majority_voter_seq.sv
// Directed self-checking bench for majority_voter_seq (WIDTH=16, CHUNK=4).
module tb_majority_voter_seq;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int CW    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_mode;
   logic [CW-1:0]    in_thresh;
   logic             out_valid;
   logic             out_ready;
   logic             out_maj;
   logic [CW-1:0]    out_count;
   logic             out_tie;

   int errors = 0;
   int checks = 0;

   majority_voter_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .in_thresh (in_thresh),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_maj   (out_maj),
      .out_count (out_count),
      .out_tie   (out_tie)
   );

   always #5 clk = ~clk;

   // Present a word at a falling edge and let the next rising edge accept it.
   task automatic send_word(input logic [WIDTH-1:0] d, input logic m, input logic [CW-1:0] t);
      @(negedge clk);
      in_data = d; in_mode = m; in_thresh = t; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Rising edges from the accept edge until out_valid is seen; 20 on timeout.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) break;
      end
      if (!out_valid) lat = 20;
   endtask

   // Take the result for one edge; ends at the following falling edge.
   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; in_mode = 1'b0;
      in_thresh = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
      checks++; if (out_maj !== 1'b0) begin errors++; $display("FAIL reset_out_maj got=%b exp=0", out_maj); end
      checks++; if (out_tie !== 1'b0) begin errors++; $display("FAIL reset_out_tie got=%b exp=0", out_tie); end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_result got=%b exp=0", out_valid); end
   endtask

   task automatic test_vectors(input string tag, input logic m,
                               input logic [WIDTH-1:0] d, input logic [CW-1:0] t,
                               input logic [CW-1:0] ec, input logic em, input logic et);
      int lat;
      send_word(d, m, t);
      wait_valid(lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", tag, lat); end
      checks++; if (out_count !== ec) begin errors++; $display("FAIL %s_count got=%0d exp=%0d", tag, out_count, ec); end
      checks++; if (out_maj !== em) begin errors++; $display("FAIL %s_maj got=%b exp=%b", tag, out_maj, em); end
      checks++; if (out_tie !== et) begin errors++; $display("FAIL %s_tie got=%b exp=%b", tag, out_tie, et); end
      take_result();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL %s_release got valid=%b ready=%b exp valid=0 ready=1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_mode0();
      test_vectors("m0_01ff", 1'b0, 16'h01FF, 5'd0, 5'd9,  1'b1, 1'b0);
      test_vectors("m0_00ff", 1'b0, 16'h00FF, 5'd0, 5'd8,  1'b0, 1'b1);
      test_vectors("m0_ffff", 1'b0, 16'hFFFF, 5'd0, 5'd16, 1'b1, 1'b0);
      test_vectors("m0_0000", 1'b0, 16'h0000, 5'd0, 5'd0,  1'b0, 1'b0);
   endtask

   task automatic test_mode1();
      test_vectors("m1_t3",  1'b1, 16'h0007, 5'd3,  5'd3,  1'b1, 1'b0);
      test_vectors("m1_t4",  1'b1, 16'h0007, 5'd4,  5'd3,  1'b0, 1'b0);
      test_vectors("m1_t0",  1'b1, 16'h0000, 5'd0,  5'd0,  1'b1, 1'b0);
      test_vectors("m1_t17", 1'b1, 16'hFFFF, 5'd17, 5'd16, 1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      int lat;
      send_word(16'hA5A5, 1'b0, 5'd0);
      wait_valid(lat);
      checks++; if (out_count !== 5'd8 || out_tie !== 1'b1 || out_maj !== 1'b0) begin
         errors++; $display("FAIL bp_first got count=%0d maj=%b tie=%b exp 8/0/1", out_count, out_maj, out_tie);
      end
      // Hammer the input side while the result is stalled.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 16'hFFFF - 16'(i); in_mode = 1'b1; in_thresh = 5'd1;
         @(posedge clk);
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 5'd8 ||
                       out_maj !== 1'b0 || out_tie !== 1'b1) begin
            errors++; $display("FAIL bp_hold%0d got valid=%b ready=%b count=%0d maj=%b tie=%b",
                               i, out_valid, in_ready, out_count, out_maj, out_tie);
         end
      end
      // Release with a new word already on the input; it must wait for IDLE.
      in_data = 16'h0003; in_mode = 1'b0; in_thresh = 5'd0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got valid=%b ready=%b exp 0/1", out_valid, in_ready);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_valid(lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL bp_next_latency got=%0d exp=4", lat); end
      checks++; if (out_count !== 5'd2 || out_maj !== 1'b0 || out_tie !== 1'b0) begin
         errors++; $display("FAIL bp_next got count=%0d maj=%b tie=%b exp 2/0/0", out_count, out_maj, out_tie);
      end
      take_result();
   endtask

   task automatic test_reset_mid();
      int lat;
      send_word(16'hFFFF, 1'b0, 5'd0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      // Now in the second COUNT cycle; out_count still holds the previous result (2).
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_count !== 5'd0 || out_maj !== 1'b0 || out_tie !== 1'b0) begin
         errors++; $display("FAIL rm_async got valid=%b count=%0d maj=%b tie=%b exp all 0",
                            out_valid, out_count, out_maj, out_tie);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
      repeat (6) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale got=%b exp=0", out_valid); end
      end
      send_word(16'h0101, 1'b0, 5'd0);
      wait_valid(lat);
      checks++; if (lat != 4 || out_count !== 5'd2 || out_maj !== 1'b0) begin
         errors++; $display("FAIL rm_next got lat=%0d count=%0d maj=%b exp 4/2/0", lat, out_count, out_maj);
      end
      take_result();
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] words [3] = '{16'h8001, 16'hFFF0, 16'h5555};
      logic [CW-1:0]    ecnt  [3] = '{5'd2, 5'd12, 5'd8};
      logic             emaj  [3] = '{1'b0, 1'b1, 1'b0};
      realtime          t_acc [3];
      int               n;
      @(negedge clk);
      out_ready = 1'b1;
      for (int w = 0; w < 3; w++) begin
         in_data = words[w]; in_mode = 1'b0; in_thresh = 5'd0; in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 20) begin @(negedge clk); n++; end
         @(posedge clk);
         t_acc[w] = $realtime;
         n = 0;
         do begin @(negedge clk); n++; end while (!out_valid && n < 20);
         checks++; if (out_valid !== 1'b1 || out_count !== ecnt[w] || out_maj !== emaj[w]) begin
            errors++; $display("FAIL b2b_word%0d got valid=%b count=%0d maj=%b exp 1/%0d/%b",
                               w, out_valid, out_count, out_maj, ecnt[w], emaj[w]);
         end
      end
      in_valid = 1'b0;
      for (int w = 1; w < 3; w++) begin
         checks++; if (t_acc[w] - t_acc[w-1] != 60.0) begin
            errors++; $display("FAIL b2b_spacing%0d got=%0t exp=60", w, t_acc[w] - t_acc[w-1]);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode1();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
